// File: rtl/pisca_leds_pkg.sv
// Shared widths, latency and the determinant type for the pisca_leds_1 triangle-area pipeline.
package pisca_leds_pkg;
   localparam int COORD_W = 11;
   localparam int DET_W   = 24;
   localparam int AREA_W  = 21;
   localparam int PROD_W  = 2 * COORD_W;
   localparam int SUM_W   = 24;
   localparam int LATENCY = 4;

   typedef logic signed [DET_W-1:0] det_t;
endpackage

// File: rtl/pisca_leds_1_if.sv
// Vertex and result bundle for pisca_leds_1; the orient line exists only with PISCALEDS1_ORIENT_EN.
interface pisca_leds_1_if;
   import pisca_leds_pkg::*;

   logic [COORD_W-1:0] ax, ay, bx, by, cx, cy;
   logic [AREA_W-1:0]  area;
   logic               area_half;
   logic               degenerate;
`ifdef PISCALEDS1_ORIENT_EN
   logic               orient;

   modport master (output ax, ay, bx, by, cx, cy,
                   input  area, area_half, degenerate, orient);
   modport slave  (input  ax, ay, bx, by, cx, cy,
                   output area, area_half, degenerate, orient);
`else
   modport master (output ax, ay, bx, by, cx, cy,
                   input  area, area_half, degenerate);
   modport slave  (input  ax, ay, bx, by, cx, cy,
                   output area, area_half, degenerate);
`endif
endinterface

// File: rtl/pisca_leds_1_tri_mul_reg.sv
// Unsigned COORD_W x COORD_W multiplier with a registered full-width product.
module tri_mul_reg
   import pisca_leds_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] a,
   input  logic [COORD_W-1:0] b,
   output logic [PROD_W-1:0]  prod
);
   logic [PROD_W-1:0] prod_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prod_reg <= '0;
      else     prod_reg <= {{COORD_W{1'b0}}, a} * {{COORD_W{1'b0}}, b};
   end

   assign prod = prod_reg;
endmodule

// File: rtl/pisca_leds_1.sv
// Four-stage triangle-area pipeline: floor(|shoelace det| / 2), half flag, collinear flag.
// Optional sign output when PISCALEDS1_ORIENT_EN is defined.
module pisca_leds_1
   import pisca_leds_pkg::*;
(
   input  logic         CLOCK_50,
   input  logic         reset,
   pisca_leds_1_if.slave bus
);
   // Coordinate slots: 0=ax 1=ay 2=bx 3=by 4=cx 5=cy.
   // Products 0..2 form the positive sum, 3..5 the negative sum.
   localparam int A_IDX [6] = '{0, 2, 4, 0, 2, 4};
   localparam int B_IDX [6] = '{3, 5, 1, 5, 1, 3};

   logic [COORD_W-1:0] coord_reg [6];
   logic [PROD_W-1:0]  prod [6];
   det_t               det_reg;
   det_t               det_next;
   logic [SUM_W-1:0]   sum_pos, sum_neg;
   logic signed [SUM_W:0] diff;
   logic [DET_W-1:0]   mag;
   logic [AREA_W-1:0]  area_reg, area_next;
   logic               half_reg;
   logic               degenerate_reg;

   // S1
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) coord_reg[i] <= '0;
      end else begin
         coord_reg[0] <= bus.ax;
         coord_reg[1] <= bus.ay;
         coord_reg[2] <= bus.bx;
         coord_reg[3] <= bus.by;
         coord_reg[4] <= bus.cx;
         coord_reg[5] <= bus.cy;
      end
   end

   // S2
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_mul
         tri_mul_reg u_mul (
            .clk  (CLOCK_50),
            .rst  (reset),
            .a    (coord_reg[A_IDX[gi]]),
            .b    (coord_reg[B_IDX[gi]]),
            .prod (prod[gi])
         );
      end
   endgenerate

   // Sums cannot overflow 24 bits; the 25-bit difference always fits back into DET_W.
   always_comb begin
      sum_pos  = {2'b00, prod[0]} + {2'b00, prod[1]} + {2'b00, prod[2]};
      sum_neg  = {2'b00, prod[3]} + {2'b00, prod[4]} + {2'b00, prod[5]};
      diff     = $signed({1'b0, sum_pos}) - $signed({1'b0, sum_neg});
      det_next = det_t'(diff);
   end

   // S3
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) det_reg <= '0;
      else       det_reg <= det_next;
   end

   always_comb begin
      mag       = det_reg[DET_W-1] ? (~det_reg + 1'b1) : det_reg;
      area_next = AREA_W'(mag >> 1);
   end

   // S4
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         area_reg       <= '0;
         half_reg       <= 1'b0;
         degenerate_reg <= 1'b0;
      end else begin
         area_reg       <= area_next;
         half_reg       <= det_reg[0];
         degenerate_reg <= (det_reg == '0);
      end
   end

   assign bus.area       = area_reg;
   assign bus.area_half  = half_reg;
   assign bus.degenerate = degenerate_reg;

`ifdef PISCALEDS1_ORIENT_EN
   logic orient_reg;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) orient_reg <= 1'b0;
      else       orient_reg <= det_reg[DET_W-1];
   end

   assign bus.orient = orient_reg;
`endif
endmodule

// File: tb/tb_pisca_leds_1.sv
// Directed bench for pisca_leds_1: reset, latency, streaming and mid-flight reset.
module tb_pisca_leds_1;
   import pisca_leds_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   pisca_leds_1_if bus ();

   pisca_leds_1 dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Vectors: ax, ay, bx, by, cx, cy and hand-computed area, half, degenerate, orient.
   localparam int NV = 5;
   int v_ax [NV] = '{1,  1,   47,  0,    0};
   int v_ay [NV] = '{82, 5,   165, 0,    0};
   int v_bx [NV] = '{47, 15,  47,  2047, 1};
   int v_by [NV] = '{1,  25,  1,   0,    1};
   int v_cx [NV] = '{47, 3,   1,   0,    2};
   int v_cy [NV] = '{165, 50, 82,  2047, 2};
   int e_area [NV] = '{3772, 295, 3772, 2095104, 0};
   int e_half [NV] = '{0, 0, 0, 1, 0};
   int e_deg  [NV] = '{0, 0, 0, 0, 1};
   int e_ori  [NV] = '{0, 0, 1, 0, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i);
      bus.ax = COORD_W'(v_ax[i]);
      bus.ay = COORD_W'(v_ay[i]);
      bus.bx = COORD_W'(v_bx[i]);
      bus.by = COORD_W'(v_by[i]);
      bus.cx = COORD_W'(v_cx[i]);
      bus.cy = COORD_W'(v_cy[i]);
   endtask

   task automatic drive_zero();
      bus.ax = '0; bus.ay = '0; bus.bx = '0;
      bus.by = '0; bus.cx = '0; bus.cy = '0;
   endtask

   task automatic check_outputs(input string tag, input int area, input int half,
                                input int deg, input int ori);
      check({tag, ".area"}, 32'(bus.area), 32'(area));
      check({tag, ".half"}, 32'(bus.area_half), 32'(half));
      check({tag, ".deg"},  32'(bus.degenerate), 32'(deg));
`ifdef PISCALEDS1_ORIENT_EN
      check({tag, ".orient"}, 32'(bus.orient), 32'(ori));
`endif
   endtask

   task automatic check_vec(input string tag, input int i);
      check_outputs(tag, e_area[i], e_half[i], e_deg[i], e_ori[i]);
      $display("txn %s vec%0d: area=%0d half=%0d deg=%0d", tag, i,
               bus.area, bus.area_half, bus.degenerate);
   endtask

   initial begin
      drive(0);
      // Asynchronous assertion between edges clears outputs with no clock.
      #2 rst = 1'b1;
      #1 check_outputs("rst_async", 0, 0, 0, 0);
      step();
      step();
      check_outputs("rst_held", 0, 0, 0, 0);

      // Release with zero vertices: zero-vertex result after the first edge.
      drive_zero();
      rst = 1'b0;
      step();
      check_outputs("zero_vtx", 0, 0, 1, 0);

      // Single-sample latency: visible only after the 4th edge.
      drive(1);
      for (int e = 1; e <= LATENCY; e++) begin
         step();
         drive_zero();
         if (e < LATENCY) check_outputs($sformatf("lat_e%0d", e), 0, 0, 1, 0);
         else             check_vec("latency", 1);
      end
      repeat (LATENCY) step();

      // Back-to-back streaming.
      for (int c = 0; c < NV + LATENCY - 1; c++) begin
         if (c < NV) drive(c);
         else        drive_zero();
         step();
         if (c >= LATENCY - 1) check_vec("stream", c - (LATENCY - 1));
      end

      // Fill the pipeline, then reset between edges.
      for (int c = 0; c < LATENCY - 1; c++) begin
         drive(c);
         step();
      end
      drive(3);
      step();
      check_vec("prefill", 0);
      #2 rst = 1'b1;
      #1 check_outputs("rst_mid", 0, 0, 0, 0);
      step();
      check_outputs("rst_mid_held", 0, 0, 0, 0);

      // First post-reset sample emerges 4 edges later; flushed data never reappears.
      rst = 1'b0;
      drive(2);
      #1 check_outputs("rel_pre_edge", 0, 0, 0, 0);
      for (int e = 1; e <= LATENCY; e++) begin
         step();
         drive_zero();
         if (e < LATENCY) check_outputs($sformatf("post_rst_e%0d", e), 0, 0, 1, 0);
         else             check_vec("post_rst", 2);
      end
      step();
      check_outputs("post_rst_zero", 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
